freq_gate_ctrl: RTL and testbench
=================================

// Module: freq_gate_ctrl
// PURPOSE
//   Gate-time sequencer for the digital frequency meter. Opens a gate of fixed length, counts the
//   single-cycle pulses from the rising-edge detector during the gate, and latches the count as the
//   frequency result. The result is held under a valid/ack handshake. The block supports one-shot
//   or continuous measurement and pulses a reset to the edge detector before each gate.
// PARAMETERS
//   GATE_CYCLES  1000000  gate length in clk cycles (>=1)
//   COUNT_W      32       width of edge counter / freq_count
//   TIMER_W      $clog2(GATE_CYCLES+1)  derived; gate timer width (localparam)
// PORTS
//   clk          in   1        system clock; all logic on posedge clk
//   rst          in   1        reset, synchronous, active-high
//   start        in   1        begin measurement; sampled only in IDLE
//   continuous   in   1        1: re-arm automatically after each ack; sampled at ack
//   abort        in   1        cancel any measurement; return to IDLE
//   edge_pulse   in   1        1-cycle rising-edge pulse from the edge detector
//   result_ack   in   1        consumer accepts freq_count when result_valid=1
//   det_rst      out  1        resets the edge detector; high only in ARM
//   gate_open    out  1        high exactly during GATE cycles
//   busy         out  1        high in any state other than IDLE
//   freq_count   out  COUNT_W  edges counted in the last completed gate
//   overflow     out  1        the counter saturated during the last completed gate
//   result_valid out  1        freq_count/overflow valid; held until acked
// BEHAVIOUR
//   Reset: state=IDLE; all outputs 0, including freq_count; timer and counter cleared.
//   States: IDLE -> ARM -> GATE -> DONE -> (IDLE | ARM). All outputs are registered and decoded from state.
//   IDLE: start=1 -> ARM. All other inputs are ignored.
//   ARM (1 cycle): det_rst=1. The edge counter, sat flag and timer clear. -> GATE.
//   GATE: exactly GATE_CYCLES cycles, with gate_open=1.
//     - edge_pulse=1 increments the counter on every GATE cycle, including the last.
//     - The counter saturates at 2^COUNT_W-1 and sets the sat flag; it never wraps.
//     - On the last GATE cycle: freq_count <= counter (+pulse, saturated); overflow <= sat.
//     - The next state is DONE.
//   DONE: result_valid=1; freq_count and overflow are stable.
//     - result_ack=1 -> result_valid=0 next cycle.
//     - Next state is ARM if continuous=1, otherwise IDLE.
//   Latency: start sampled at cycle T -> ARM at T+1 -> GATE at T+2..T+1+GATE_CYCLES.
//     result_valid rises at T+2+GATE_CYCLES. In continuous mode, ack at A -> ARM at A+1.
//   edge_pulse outside GATE (IDLE/ARM/DONE) is never counted.
//   abort=1 in any state -> IDLE next cycle.
//     - result_valid and gate_open drop; freq_count/overflow keep their last completed values.
//     - abort has priority over start and result_ack in the same cycle.
//   start while busy is ignored. result_ack while result_valid=0 is ignored.
//   rst mid-operation: identical to the reset state on the next edge, and any partial count is discarded.
// TESTING  (GATE_CYCLES=20, COUNT_W=4)
//   1. Assert rst for 2 cycles with arbitrary inputs -> all outputs 0, busy=0.
//   2. start at T; edge_pulse every 2nd cycle.
//      -> det_rst=1 at T+1; gate_open T+2..T+21; result_valid at T+22; freq_count=10, overflow=0.
//   3. edge_pulse held high through the gate -> freq_count=15, overflow=1, no wrap.
//   4. edge_pulse only in IDLE/ARM/DONE plus 3 pulses in GATE.
//      -> freq_count=3. Delay ack 5 cycles -> result stable, valid held.
//   5. abort at gate cycle 7 (also repeat with rst) -> IDLE next cycle, busy=0, result_valid never rises.
//      Also start+abort in the same cycle -> stays IDLE.
//   6. continuous=1, two runs with 4 then 6 pulses; start pulsed mid-gate.
//      -> results 4 then 6; ARM the cycle after each ack; stray start ignored.

Source files
------------

// File: rtl/freq_gate_ctrl.sv
// Gate-time sequencer for the frequency meter: arms the edge detector, counts edge pulses over a
// fixed gate and holds the saturated count under a valid/ack handshake.
module freq_gate_ctrl #(
   parameter int GATE_CYCLES = 1000000,
   parameter int COUNT_W     = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               continuous,
   input  logic               abort,
   input  logic               edge_pulse,
   input  logic               result_ack,
   output logic               det_rst,
   output logic               gate_open,
   output logic               busy,
   output logic [COUNT_W-1:0] freq_count,
   output logic               overflow,
   output logic               result_valid
);

   localparam int TIMER_W = $clog2(GATE_CYCLES + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ARM,
      S_GATE,
      S_DONE
   } state_e;

   state_e             state_q, state_d;
   logic [TIMER_W-1:0] timer_q, timer_d;
   logic [COUNT_W-1:0] count_q, count_d;
   logic [COUNT_W-1:0] freq_q, freq_d;
   logic               sat_q, sat_d;
   logic               ovf_q, ovf_d;

   logic [COUNT_W-1:0] count_next;
   logic               sat_next;
   logic               last_gate;

   // NOTE: every signal assigned in this block gets a default first, so no path leaves it
   // unassigned and no latch is inferred.
   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q;
      count_d    = count_q;
      sat_d      = sat_q;
      freq_d     = freq_q;
      ovf_d      = ovf_q;
      count_next = count_q;
      sat_next   = sat_q;
      last_gate  = (timer_q == TIMER_W'(GATE_CYCLES - 1));

      // The sat flag marks a pulse that arrived while the counter was already full (a lost edge).
      if (edge_pulse) begin
         if (count_q == {COUNT_W{1'b1}}) begin
            sat_next = 1'b1;
         end else begin
            count_next = count_q + COUNT_W'(1);
         end
      end

      unique case (state_q)
         S_IDLE: begin
            if (start) state_d = S_ARM;
         end
         S_ARM: begin
            timer_d = '0;
            count_d = '0;
            sat_d   = 1'b0;
            state_d = S_GATE;
         end
         S_GATE: begin
            count_d = count_next;
            sat_d   = sat_next;
            timer_d = timer_q + TIMER_W'(1);
            if (last_gate) begin
               state_d = S_DONE;
               // An abort on the final gate cycle leaves the previous result untouched.
               if (!abort) begin
                  freq_d = count_next;
                  ovf_d  = sat_next;
               end
            end
         end
         S_DONE: begin
            if (result_ack) state_d = continuous ? S_ARM : S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (abort) state_d = S_IDLE;
   end

   // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         timer_q <= '0;
         count_q <= '0;
         sat_q   <= 1'b0;
         freq_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         count_q <= count_d;
         sat_q   <= sat_d;
         freq_q  <= freq_d;
         ovf_q   <= ovf_d;
      end
   end

   assign det_rst      = (state_q == S_ARM);
   assign gate_open    = (state_q == S_GATE);
   assign busy         = (state_q != S_IDLE);
   assign result_valid = (state_q == S_DONE);
   assign freq_count   = freq_q;
   assign overflow     = ovf_q;

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// Self-checking bench for freq_gate_ctrl: vector table, directed corner sequences and random
// stimulus compared against a cycle-position reference model.
module tb_freq_gate_ctrl;

   localparam int G    = 20;
   localparam int CW   = 4;
   localparam int MAXC = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst, start, continuous, abort, edge_pulse, result_ack;
   logic          det_rst, gate_open, busy, overflow, result_valid;
   logic [CW-1:0] freq_count;

   always #5 clk = ~clk;

   freq_gate_ctrl #(.GATE_CYCLES(G), .COUNT_W(CW)) dut (
      .clk(clk), .rst(rst), .start(start), .continuous(continuous), .abort(abort),
      .edge_pulse(edge_pulse), .result_ack(result_ack), .det_rst(det_rst),
      .gate_open(gate_open), .busy(busy), .freq_count(freq_count), .overflow(overflow),
      .result_valid(result_valid)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference model: position in the measurement (0 idle, 1 arm, 2..G+1 gate, G+2 done) and an
   // unbounded edge tally that is clamped only when the result is published.
   int m_pos = 0, m_edges = 0, m_res = 0;
   bit m_ovf = 1'b0;

   function automatic void model_step(input bit r, s, c, a, p, k);
      if (r) begin
         m_pos = 0; m_edges = 0; m_res = 0; m_ovf = 1'b0;
      end else if (a) begin
         m_pos = 0;
      end else if (m_pos == 0) begin
         if (s) m_pos = 1;
      end else if (m_pos == 1) begin
         m_edges = 0;
         m_pos   = 2;
      end else if (m_pos <= G + 1) begin
         if (p) m_edges++;
         if (m_pos == G + 1) begin
            m_res = (m_edges > MAXC) ? MAXC : m_edges;
            m_ovf = (m_edges > MAXC);
            m_pos = G + 2;
         end else begin
            m_pos++;
         end
      end else if (k) begin
         m_pos = c ? 1 : 0;
      end
   endfunction

   task automatic cyc(input bit r, s, c, a, p, k);
      rst = r; start = s; continuous = c; abort = a; edge_pulse = p; result_ack = k;
      model_step(r, s, c, a, p, k);
      @(posedge clk);
      #1;
      check("m_det_rst",   32'(det_rst),      32'(m_pos == 1));
      check("m_gate_open", 32'(gate_open),    32'(m_pos >= 2 && m_pos <= G + 1));
      check("m_busy",      32'(busy),         32'(m_pos != 0));
      check("m_valid",     32'(result_valid), 32'(m_pos == G + 2));
      check("m_count",     32'(freq_count),   32'(m_res));
      check("m_overflow",  32'(overflow),     32'(m_ovf));
   endtask

   // Applies vectors k = first_k..last_k of a measurement; k=0 is the start cycle in IDLE.
   task automatic apply_seq(input int first_k, input int last_k, input bit [63:0] pulse_at,
                            input bit [63:0] start_at, input bit c);
      for (int k = first_k; k <= last_k; k++) cyc(1'b0, start_at[k], c, 1'b0, pulse_at[k], 1'b0);
   endtask

   typedef struct {
      bit r, s, c, a, p, k;
      bit e_det, e_gate, e_busy, e_valid;
      int e_cnt;
      bit e_ovf;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input bit r, s, c, a, p, k, e_det, e_gate, e_busy, e_valid,
                               input int e_cnt, input bit e_ovf);
      vec_t v;
      v.r = r; v.s = s; v.c = c; v.a = a; v.p = p; v.k = k;
      v.e_det = e_det; v.e_gate = e_gate; v.e_busy = e_busy; v.e_valid = e_valid;
      v.e_cnt = e_cnt; v.e_ovf = e_ovf;
      return v;
   endfunction

   initial begin
      bit [63:0] pm, sm;
      int        dens;

      // Reset with arbitrary inputs held high, then a start at k=0 with pulses on even k.
      tbl.push_back(mk(1, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 1, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0));
      for (int k = 0; k <= 24; k++) begin
         tbl.push_back(mk(1'b0, k == 0, 1'b0, 1'b0, (k % 2) == 0, k == 23,
                          k == 0, k >= 1 && k <= G, k <= G + 2, k >= G + 1 && k <= G + 2,
                          (k >= G + 1) ? 10 : 0, 1'b0));
      end

      for (int i = 0; i < tbl.size(); i++) begin
         cyc(tbl[i].r, tbl[i].s, tbl[i].c, tbl[i].a, tbl[i].p, tbl[i].k);
         check($sformatf("tbl%0d_det_rst", i),   32'(det_rst),      32'(tbl[i].e_det));
         check($sformatf("tbl%0d_gate_open", i), 32'(gate_open),    32'(tbl[i].e_gate));
         check($sformatf("tbl%0d_busy", i),      32'(busy),         32'(tbl[i].e_busy));
         check($sformatf("tbl%0d_valid", i),     32'(result_valid), 32'(tbl[i].e_valid));
         check($sformatf("tbl%0d_count", i),     32'(freq_count),   32'(tbl[i].e_cnt));
         check($sformatf("tbl%0d_overflow", i),  32'(overflow),     32'(tbl[i].e_ovf));
      end

      // Pulse held high everywhere: the count clamps at 15 and overflow is flagged.
      apply_seq(0, G + 1, '1, 64'd1, 1'b0);
      check("sat_valid", 32'(result_valid), 32'd1);
      check("sat_count", 32'(freq_count), 32'(MAXC));
      check("sat_overflow", 32'(overflow), 32'd1);
      cyc(0, 0, 0, 0, 1, 1);
      check("sat_ack_valid", 32'(result_valid), 32'd0);
      check("sat_ack_count", 32'(freq_count), 32'(MAXC));

      // Pulses in IDLE/ARM/DONE are ignored; three in the gate, one on the last gate cycle.
      pm = '0;
      pm[0] = 1'b1; pm[1] = 1'b1; pm[2] = 1'b1; pm[9] = 1'b1; pm[G + 1] = 1'b1;
      apply_seq(0, G + 1, pm, 64'd1, 1'b0);
      for (int d = 0; d < 5; d++) begin
         cyc(0, 0, 0, 0, 1, 0);
         check("hold_valid", 32'(result_valid), 32'd1);
         check("hold_count", 32'(freq_count), 32'd3);
         check("hold_overflow", 32'(overflow), 32'd0);
      end
      cyc(0, 0, 0, 0, 0, 1);
      check("hold_ack_valid", 32'(result_valid), 32'd0);

      // Abort during gate cycle 7: back to IDLE, previous result kept, valid never rises.
      apply_seq(0, 7, '1, 64'd1, 1'b0);
      cyc(0, 0, 0, 1, 1, 0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_gate", 32'(gate_open), 32'd0);
      check("abort_count", 32'(freq_count), 32'd3);
      for (int d = 0; d < G + 5; d++) cyc(0, 0, 0, 0, 1, 1);
      check("abort_no_valid", 32'(result_valid), 32'd0);

      // Same again using rst, which also clears the held result.
      apply_seq(0, 7, '1, 64'd1, 1'b0);
      cyc(1, 0, 0, 0, 1, 0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_count", 32'(freq_count), 32'd0);
      for (int d = 0; d < G + 5; d++) cyc(0, 0, 0, 0, 1, 0);
      check("rst_no_valid", 32'(result_valid), 32'd0);

      cyc(0, 1, 0, 1, 0, 0);
      check("start_abort_busy", 32'(busy), 32'd0);
      check("start_abort_det", 32'(det_rst), 32'd0);

      // Continuous mode: 4 then 6 pulses, stray starts mid-gate, ARM right after each ack.
      pm = '0; pm[3] = 1; pm[5] = 1; pm[7] = 1; pm[9] = 1;
      sm = '0; sm[0] = 1; sm[10] = 1;
      apply_seq(0, G + 1, pm, sm, 1'b1);
      check("cont1_count", 32'(freq_count), 32'd4);
      check("cont1_valid", 32'(result_valid), 32'd1);
      cyc(0, 0, 1, 0, 0, 1);
      check("cont1_rearm", 32'(det_rst), 32'd1);
      pm = '0; pm[2] = 1; pm[4] = 1; pm[6] = 1; pm[12] = 1; pm[15] = 1; pm[G + 1] = 1;
      sm = '0; sm[11] = 1;
      apply_seq(1, G + 1, pm, sm, 1'b1);
      check("cont2_count", 32'(freq_count), 32'd6);
      check("cont2_valid", 32'(result_valid), 32'd1);
      cyc(0, 0, 0, 0, 0, 1);
      check("cont2_idle", 32'(busy), 32'd0);

      // Random traffic with varying pulse density.
      dens = 50;
      for (int n = 0; n < 3000; n++) begin
         if (n % 200 == 0) dens = (n / 200 % 3 == 0) ? 10 : ((n / 200 % 3 == 1) ? 50 : 95);
         cyc($urandom_range(0, 99) < 1, $urandom_range(0, 99) < 25, $urandom_range(0, 1) == 1,
             $urandom_range(0, 99) < 2, $urandom_range(0, 99) < dens,
             $urandom_range(0, 99) < 30);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
